// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus monitor.
// Receiver FSM states and frame geometry.
package i2c_pkg;
    localparam int I2C_BYTE_W      = 8;
    localparam int I2C_ACK_BIT_IDX = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ACK
    } i2c_state_e;
endpackage

// File: rtl/i2c_sync.sv
// Multi-stage level synchronizer, resets to 1 (idle bus level).
// Output lags the input by SYNC_STAGES clock cycles.
module i2c_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RSTB,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] ff_q;
    logic [SYNC_STAGES-1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) ff_q <= '1;
        else       ff_q <= ff_d;
    end

    assign q = ff_q[SYNC_STAGES-1];
endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus-condition detector and byte receiver.
// Detects SCL edges, START/STOP, tracks busy, shifts bytes and ACK.
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RSTB,
    input  logic       SCL_DG,
    input  logic       SDA_DG,
    input  logic       EN,
    output logic       SCL_RISE,
    output logic       SCL_FALL,
    output logic       START_P,
    output logic       RSTART_P,
    output logic       STOP_P,
    output logic       BUS_BUSY,
    output logic [7:0] RX_DATA,
    output logic       RX_VLD,
    output logic       ACK_SLOT,
    output logic       ACK_VLD,
    output logic       ACK_BIT,
    output logic [3:0] BIT_CNT
);
    localparam logic [3:0] LAST_BIT = 4'(I2C_BYTE_W - 1);
    localparam logic [3:0] ACK_IDX  = 4'(I2C_ACK_BIT_IDX);

    logic scl_s, sda_s;
    logic scl_p_q, sda_p_q;
    logic rise_c, fall_c, start_c, stop_c;

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic rx_vld_q, rx_vld_d;
    logic ack_slot_q, ack_slot_d;
    logic ack_vld_q, ack_vld_d;
    logic ack_bit_q, ack_bit_d;
    logic busy_q, busy_d;
    logic rise_q, fall_q;
    logic start_p_q, start_p_d;
    logic rstart_p_q, rstart_p_d;
    logic stop_p_q, stop_p_d;

    i2c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
        .CLK(CLK), .RSTB(RSTB), .d(SCL_DG), .q(scl_s)
    );
    i2c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
        .CLK(CLK), .RSTB(RSTB), .d(SDA_DG), .q(sda_s)
    );

    // Conditions require SCL stable high, so a simultaneous SCL/SDA change is only an edge
    always_comb begin
        rise_c  = scl_s & ~scl_p_q;
        fall_c  = ~scl_s & scl_p_q;
        start_c = scl_p_q & scl_s & sda_p_q & ~sda_s;
        stop_c  = scl_p_q & scl_s & ~sda_p_q & sda_s;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_vld_d   = 1'b0;
        ack_slot_d = ack_slot_q;
        ack_vld_d  = 1'b0;
        ack_bit_d  = ack_bit_q;
        busy_d     = busy_q;
        if (start_c)     busy_d = 1'b1;
        else if (stop_c) busy_d = 1'b0;
        start_p_d  = EN & start_c;
        rstart_p_d = EN & start_c & busy_q;
        stop_p_d   = EN & stop_c;

        if (!EN) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            ack_slot_d = 1'b0;
        end else if (stop_c) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            ack_slot_d = 1'b0;
        end else if (start_c) begin
            state_d    = DATA;
            bit_cnt_d  = '0;
            shift_d    = '0;
            ack_slot_d = 1'b0;
        end else begin
            unique case (state_q)
                DATA: begin
                    if (rise_c && bit_cnt_q < ACK_IDX) begin
                        shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d = {shift_q[I2C_BYTE_W-2:0], sda_s};
                            rx_vld_d  = 1'b1;
                        end
                    end else if (fall_c && bit_cnt_q == ACK_IDX) begin
                        state_d    = ACK;
                        ack_slot_d = 1'b1;
                    end
                end
                ACK: begin
                    if (rise_c) begin
                        ack_bit_d = sda_s;
                        ack_vld_d = 1'b1;
                    end else if (fall_c) begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        ack_slot_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_vld_q   <= 1'b0;
            ack_slot_q <= 1'b0;
            ack_vld_q  <= 1'b0;
            ack_bit_q  <= 1'b1;
            busy_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_p_q  <= 1'b0;
            rstart_p_q <= 1'b0;
            stop_p_q   <= 1'b0;
        end else begin
            scl_p_q    <= scl_s;
            sda_p_q    <= sda_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_vld_q   <= rx_vld_d;
            ack_slot_q <= ack_slot_d;
            ack_vld_q  <= ack_vld_d;
            ack_bit_q  <= ack_bit_d;
            busy_q     <= busy_d;
            rise_q     <= rise_c;
            fall_q     <= fall_c;
            start_p_q  <= start_p_d;
            rstart_p_q <= rstart_p_d;
            stop_p_q   <= stop_p_d;
        end
    end

    assign SCL_RISE = rise_q;
    assign SCL_FALL = fall_q;
    assign START_P  = start_p_q;
    assign RSTART_P = rstart_p_q;
    assign STOP_P   = stop_p_q;
    assign BUS_BUSY = busy_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VLD   = rx_vld_q;
    assign ACK_SLOT = ack_slot_q;
    assign ACK_VLD  = ack_vld_q;
    assign ACK_BIT  = ack_bit_q;
    assign BIT_CNT  = bit_cnt_q;
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: bus transactions driven
// at the pins, pulses counted, results compared to hand values.
module tb_i2c_bus_monitor;
    logic       CLK = 1'b0;
    logic       RSTB = 1'b0;
    logic       SCL_DG = 1'b1;
    logic       SDA_DG = 1'b1;
    logic       EN = 1'b1;
    logic       SCL_RISE, SCL_FALL, START_P, RSTART_P, STOP_P;
    logic       BUS_BUSY, RX_VLD, ACK_SLOT, ACK_VLD, ACK_BIT;
    logic [7:0] RX_DATA;
    logic [3:0] BIT_CNT;

    int checks = 0;
    int errors = 0;

    int rise_cnt, fall_cnt, start_cnt, rstart_cnt, stop_cnt;
    int rx_cnt, ack_cnt, orphan_cnt, rstart_idx;
    logic [7:0] rx_log [4];
    logic       ack_log [4];

    i2c_bus_monitor #(.SYNC_STAGES(2)) dut (
        .CLK(CLK), .RSTB(RSTB), .SCL_DG(SCL_DG), .SDA_DG(SDA_DG),
        .EN(EN), .SCL_RISE(SCL_RISE), .SCL_FALL(SCL_FALL),
        .START_P(START_P), .RSTART_P(RSTART_P), .STOP_P(STOP_P),
        .BUS_BUSY(BUS_BUSY), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
        .ACK_SLOT(ACK_SLOT), .ACK_VLD(ACK_VLD), .ACK_BIT(ACK_BIT),
        .BIT_CNT(BIT_CNT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RSTB) begin
            if (SCL_RISE) rise_cnt++;
            if (SCL_FALL) fall_cnt++;
            if (START_P) start_cnt++;
            if (STOP_P) stop_cnt++;
            if (RSTART_P) begin
                rstart_cnt++;
                rstart_idx = start_cnt;
                if (!START_P) orphan_cnt++;
            end
            if (RX_VLD) begin
                rx_log[rx_cnt % 4] = RX_DATA;
                rx_cnt++;
            end
            if (ACK_VLD) begin
                ack_log[ack_cnt % 4] = ACK_BIT;
                ack_cnt++;
            end
        end
    end

    task automatic wt(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clr();
        rise_cnt = 0; fall_cnt = 0; start_cnt = 0; rstart_cnt = 0;
        stop_cnt = 0; rx_cnt = 0; ack_cnt = 0; orphan_cnt = 0;
        rstart_idx = 0;
    endtask

    task automatic bus_start();
        SDA_DG = 1'b1; wt(4);
        SCL_DG = 1'b1; wt(4);
        SDA_DG = 1'b0; wt(4);
        SCL_DG = 1'b0; wt(4);
    endtask

    task automatic bus_bit(input logic b);
        SDA_DG = b;    wt(4);
        SCL_DG = 1'b1; wt(4);
        SCL_DG = 1'b0; wt(4);
    endtask

    task automatic bus_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bus_bit(v[i]);
    endtask

    task automatic bus_stop();
        SDA_DG = 1'b0; wt(4);
        SCL_DG = 1'b1; wt(4);
        SDA_DG = 1'b1; wt(8);
    endtask

    task automatic test_reset();
        RSTB = 1'b0; SCL_DG = 1'b1; SDA_DG = 1'b1; EN = 1'b1;
        clr();
        wt(3);
        checks++;
        if ({SCL_RISE, SCL_FALL, START_P, RSTART_P, STOP_P, RX_VLD, ACK_VLD} !== 7'b0) begin
            $display("FAIL reset_pulses: got %b exp 0",
                {SCL_RISE, SCL_FALL, START_P, RSTART_P, STOP_P, RX_VLD, ACK_VLD});
            errors++;
        end
        checks++;
        if ({BUS_BUSY, RX_DATA, ACK_BIT, ACK_SLOT, BIT_CNT} !== {1'b0, 8'h00, 1'b1, 1'b0, 4'd0}) begin
            $display("FAIL reset_state: busy=%b rx=%h ackbit=%b slot=%b cnt=%0d",
                BUS_BUSY, RX_DATA, ACK_BIT, ACK_SLOT, BIT_CNT);
            errors++;
        end
        RSTB = 1'b1;
        wt(20);
        checks++;
        if (rise_cnt + fall_cnt + start_cnt + stop_cnt + rx_cnt + ack_cnt + rstart_cnt != 0) begin
            $display("FAIL reset_quiet: got %0d pulses exp 0",
                rise_cnt + fall_cnt + start_cnt + stop_cnt + rx_cnt + ack_cnt + rstart_cnt);
            errors++;
        end
        checks++;
        if (BUS_BUSY !== 1'b0 || BIT_CNT !== 4'd0) begin
            $display("FAIL reset_idle: busy=%b cnt=%0d exp 0/0", BUS_BUSY, BIT_CNT);
            errors++;
        end
    endtask

    task automatic test_byte_ack();
        clr();
        bus_start();
        checks++;
        if (BUS_BUSY !== 1'b1) begin
            $display("FAIL ba_busy_set: got %b exp 1", BUS_BUSY);
            errors++;
        end
        bus_byte(8'hA5);
        checks++;
        if (ACK_SLOT !== 1'b1 || BIT_CNT !== 4'd8) begin
            $display("FAIL ba_ack_slot: slot=%b cnt=%0d exp 1/8", ACK_SLOT, BIT_CNT);
            errors++;
        end
        bus_bit(1'b0);
        checks++;
        if (ACK_SLOT !== 1'b0 || BIT_CNT !== 4'd0) begin
            $display("FAIL ba_after_ack: slot=%b cnt=%0d exp 0/0", ACK_SLOT, BIT_CNT);
            errors++;
        end
        bus_stop();
        checks++;
        if (start_cnt != 1 || stop_cnt != 1 || rstart_cnt != 0) begin
            $display("FAIL ba_conds: start=%0d stop=%0d rstart=%0d exp 1/1/0",
                start_cnt, stop_cnt, rstart_cnt);
            errors++;
        end
        checks++;
        if (rx_cnt != 1 || rx_log[0] !== 8'hA5 || RX_DATA !== 8'hA5) begin
            $display("FAIL ba_rx: cnt=%0d data=%h exp 1/a5", rx_cnt, rx_log[0]);
            errors++;
        end
        checks++;
        if (ack_cnt != 1 || ack_log[0] !== 1'b0 || ACK_BIT !== 1'b0) begin
            $display("FAIL ba_ack: cnt=%0d bit=%b exp 1/0", ack_cnt, ack_log[0]);
            errors++;
        end
        checks++;
        if (BUS_BUSY !== 1'b0) begin
            $display("FAIL ba_busy_clr: got %b exp 0", BUS_BUSY);
            errors++;
        end
    endtask

    task automatic test_rstart();
        clr();
        bus_start();
        bus_byte(8'h3C);
        bus_bit(1'b1);
        bus_start();
        bus_byte(8'h81);
        bus_bit(1'b0);
        bus_stop();
        checks++;
        if (start_cnt != 2 || rstart_cnt != 1 || rstart_idx != 2 || orphan_cnt != 0) begin
            $display("FAIL rs_pulses: start=%0d rstart=%0d at=%0d orphan=%0d exp 2/1/2/0",
                start_cnt, rstart_cnt, rstart_idx, orphan_cnt);
            errors++;
        end
        checks++;
        if (rx_cnt != 2 || rx_log[0] !== 8'h3C || rx_log[1] !== 8'h81) begin
            $display("FAIL rs_rx: cnt=%0d d0=%h d1=%h exp 2/3c/81",
                rx_cnt, rx_log[0], rx_log[1]);
            errors++;
        end
        checks++;
        if (ack_cnt != 2 || ack_log[0] !== 1'b1 || ack_log[1] !== 1'b0) begin
            $display("FAIL rs_ack: cnt=%0d a0=%b a1=%b exp 2/1/0",
                ack_cnt, ack_log[0], ack_log[1]);
            errors++;
        end
    endtask

    task automatic test_partial();
        clr();
        bus_start();
        for (int i = 0; i < 4; i++) bus_bit(i[0]);
        checks++;
        if (BIT_CNT !== 4'd4) begin
            $display("FAIL pa_mid_cnt: got %0d exp 4", BIT_CNT);
            errors++;
        end
        bus_stop();
        for (int i = 0; i < 3; i++) begin
            SCL_DG = 1'b0; wt(4);
            SCL_DG = 1'b1; wt(4);
        end
        checks++;
        if (rx_cnt != 0 || BIT_CNT !== 4'd0 || ACK_SLOT !== 1'b0) begin
            $display("FAIL pa_discard: rx=%0d cnt=%0d slot=%b exp 0/0/0",
                rx_cnt, BIT_CNT, ACK_SLOT);
            errors++;
        end
    endtask

    task automatic test_same_cycle();
        clr();
        SCL_DG = 1'b0; SDA_DG = 1'b0; wt(6);
        SCL_DG = 1'b1; SDA_DG = 1'b1; wt(6);
        checks++;
        if (fall_cnt != 1 || rise_cnt != 1) begin
            $display("FAIL sc_edges: fall=%0d rise=%0d exp 1/1", fall_cnt, rise_cnt);
            errors++;
        end
        checks++;
        if (start_cnt != 0 || stop_cnt != 0 || BUS_BUSY !== 1'b0) begin
            $display("FAIL sc_no_cond: start=%0d stop=%0d busy=%b exp 0/0/0",
                start_cnt, stop_cnt, BUS_BUSY);
            errors++;
        end
    endtask

    task automatic test_en_low();
        clr();
        EN = 1'b0;
        bus_start();
        checks++;
        if (BUS_BUSY !== 1'b1) begin
            $display("FAIL en_busy_set: got %b exp 1", BUS_BUSY);
            errors++;
        end
        bus_byte(8'hFF);
        bus_bit(1'b1);
        bus_stop();
        checks++;
        if (rx_cnt != 0 || start_cnt != 0 || stop_cnt != 0 || ack_cnt != 0) begin
            $display("FAIL en_blocked: rx=%0d start=%0d stop=%0d ack=%0d exp 0",
                rx_cnt, start_cnt, stop_cnt, ack_cnt);
            errors++;
        end
        checks++;
        if (rise_cnt != 10 || fall_cnt != 10 || BUS_BUSY !== 1'b0 || BIT_CNT !== 4'd0) begin
            $display("FAIL en_edges: rise=%0d fall=%0d busy=%b cnt=%0d exp 10/10/0/0",
                rise_cnt, fall_cnt, BUS_BUSY, BIT_CNT);
            errors++;
        end
        clr();
        bus_start();
        for (int i = 0; i < 3; i++) bus_bit(1'b0);
        EN = 1'b1;
        for (int i = 0; i < 5; i++) bus_bit(1'b1);
        bus_bit(1'b0);
        checks++;
        if (rx_cnt != 0 || BIT_CNT !== 4'd0 || ack_cnt != 0) begin
            $display("FAIL en_mid_wait: rx=%0d cnt=%0d ack=%0d exp 0/0/0",
                rx_cnt, BIT_CNT, ack_cnt);
            errors++;
        end
        bus_start();
        bus_byte(8'h5A);
        bus_bit(1'b0);
        bus_stop();
        checks++;
        if (rx_cnt != 1 || rx_log[0] !== 8'h5A || rstart_cnt != 1 || stop_cnt != 1) begin
            $display("FAIL en_resume: rx=%0d d=%h rstart=%0d stop=%0d exp 1/5a/1/1",
                rx_cnt, rx_log[0], rstart_cnt, stop_cnt);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_byte_ack();
        test_rstart();
        test_partial();
        test_same_cycle();
        test_en_low();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Synchronous I2C bus-condition detector and byte receiver sitting directly downstream of the per-pin deglitch stage. Takes the deglitched SCL and SDA levels, resynchronizes them into the system clock domain, and detects SCL edges, START, repeated START and STOP. Tracks bus busy and shifts in 8-bit bytes plus the ACK bit for the slave/master protocol FSMs above it.

## Interface
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (min 2)
- CLK  in  1  system clock, rising edge
- RSTB  in  1  asynchronous active-low reset
- SCL_DG  in  1  deglitched SCL level from SCL deglitch stage (async to CLK)
- SDA_DG  in  1  deglitched SDA level from SDA deglitch stage (async to CLK)
- EN  in  1  block enable; low forces receiver idle
- SCL_RISE  out  1  one-cycle pulse, synchronized SCL 0→1
- SCL_FALL  out  1  one-cycle pulse, synchronized SCL 1→0
- START_P  out  1  one-cycle pulse on any START (incl. repeated)
- RSTART_P  out  1  one-cycle pulse on START while BUS_BUSY=1
- STOP_P  out  1  one-cycle pulse on STOP
- BUS_BUSY  out  1  set by START, cleared by STOP
- RX_DATA  out  8  last received byte, MSB first on bus
- RX_VLD  out  1  one-cycle pulse, RX_DATA updated
- ACK_SLOT  out  1  high during 9th clock period (ACK/NACK phase)
- ACK_VLD  out  1  one-cycle pulse, ACK_BIT valid
- ACK_BIT  out  1  SDA sampled on 9th SCL rise (0=ACK, 1=NACK)
- BIT_CNT  out  4  bits received in current frame, 0..8

## Operation
- Synchronizers reset to 1 (idle bus); run continuously, independent of EN.
- Edge/condition logic compares current synchronized (scl_s, sda_s) with registered previous (scl_p, sda_p).
- START: scl_p=scl_s=1, sda_p=1, sda_s=0. STOP: scl_p=scl_s=1, sda_p=0, sda_s=1.
- SCL and SDA changing in same cycle: SCL edge pulse only; no START/STOP.
- BUS_BUSY: set on START, cleared on STOP; tracks regardless of EN.
- FSM states IDLE, DATA, ACK.
- IDLE: SCL edges ignored; START → DATA, BIT_CNT=0, shift register cleared.
- DATA: on SCL_RISE shift sda_s into LSB, BIT_CNT+1; on 8th rise RX_DATA←{shift[6:0],sda_s}, RX_VLD pulse, BIT_CNT=8. On next SCL_FALL with BIT_CNT=8 → ACK, ACK_SLOT=1.
- ACK: on SCL_RISE ACK_BIT←sda_s, ACK_VLD pulse; on following SCL_FALL → DATA, BIT_CNT=0, ACK_SLOT=0.
- START in DATA/ACK (repeated START): → DATA, BIT_CNT=0, shift cleared, ACK_SLOT=0, partial byte discarded, no RX_VLD.
- STOP in any state: → IDLE, BIT_CNT=0, ACK_SLOT=0; partial byte discarded.
- EN low: FSM held IDLE, BIT_CNT=0, ACK_SLOT=0, RX_VLD/ACK_VLD/START_P/RSTART_P/STOP_P forced 0; SCL_RISE/SCL_FALL and BUS_BUSY still active. EN rising mid-frame: receiver waits for next START.
- RX_DATA and ACK_BIT hold value until next update.

## Timing
- Reset: all pulses 0, BUS_BUSY 0, RX_DATA 8'h00, ACK_BIT 1, ACK_SLOT 0, BIT_CNT 0, FSM IDLE, scl_p/sda_p 1.
- Input change to synchronized level: SYNC_STAGES cycles; to any pulse output: SYNC_STAGES+1 cycles (all outputs registered).
- RX_VLD asserted same cycle as RX_DATA update, coincident-plus-zero with registered 8th SCL_RISE effects (i.e. SYNC_STAGES+1 after 8th SCL rising input).
- BUS_BUSY changes in same cycle as START_P/STOP_P.
- RSTART_P evaluated against BUS_BUSY before update; always coincident with START_P.
- Minimum supported SCL high/low time: 3 CLK cycles after deglitch.

## Structure
- Shared package i2c_pkg: FSM state enum (IDLE, DATA, ACK), I2C_BYTE_W=8, I2C_ACK_BIT_IDX=8.
- Sub-module i2c_sync: SYNC_STAGES-deep flop chain with async active-low reset to 1; instantiated for SCL and SDA.

## Test plan
- Reset with SCL=SDA=1 → all outputs at reset values, no pulses for 20 cycles after RSTB release.
- START, byte 8'hA5, ACK (SDA=0), STOP → START_P once, RX_VLD once with RX_DATA=8'hA5, ACK_VLD with ACK_BIT=0, STOP_P once, BUS_BUSY 1 from START to STOP.
- START, 8'h3C, NACK, repeated START, 8'h81 → RSTART_P=1 on second START only, RX_DATA 8'h3C then 8'h81, first ACK_BIT=1.
- START, 4 bits, STOP → no RX_VLD, BIT_CNT back to 0, FSM IDLE.
- SCL and SDA toggled in same CLK cycle while SCL high → SCL_FALL only, no START_P/STOP_P.
- EN=0 through full transaction 8'hFF → no RX_VLD/START_P, BUS_BUSY still 1 then 0; EN raised mid-byte → no RX_VLD until next START.
